logic_unit_serial: RTL and testbench

- Parametrised, handshaked bitwise logic unit; successor to the fixed 32-bit combinational inverter.
- Supports 8 bitwise ops, including NOT.
- Processes operands CHUNK bits per cycle under a small FSM, so wide datapaths reuse narrow logic.
- Sits beside the adder/shifter in the ALU execute stage; valid/ready on both sides.

---
 rtl/logic_unit_serial.sv | 132 +++++++++++++
 tb/tb_logic_unit_serial.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_serial.sv
// logic_unit_serial
//   Handshaked bitwise logic unit. The operands are latched on accept and then
//   processed CHUNK bits per cycle, so a wide datapath reuses one narrow slice
//   of logic. N = WIDTH/CHUNK beats per operation.
//
//   state | meaning
//   IDLE  | waiting for in_valid; in_ready high
//   BUSY  | one result chunk written per cycle; busy high
//   DONE  | result/zero valid and held until out_ready
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operation handshake (op, a, b sampled on accept)
//   op [2:0]             : 000 ~a, 001 a&b, 010 a|b, 011 a^b,
//                          100 nand, 101 nor, 110 xnor, 111 a
//   a, b [WIDTH-1:0]     : operands
//   out_valid / out_ready: result handshake
//   result [WIDTH-1:0]   : assembled result
//   zero                 : result == 0, updated on DONE entry
//   busy                 : high while in BUSY
module logic_unit_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state;
  logic [N-1:0][CHUNK-1:0]     a_q;
  logic [N-1:0][CHUNK-1:0]     b_q;
  logic [N-1:0][CHUNK-1:0]     res_q;
  logic [N-1:0][CHUNK-1:0]     res_next;
  logic [2:0]                  op_q;
  logic [CW-1:0]               cnt;
  logic [CHUNK-1:0]            chunk_res;

  function automatic logic [CHUNK-1:0] bit_op(input logic [2:0] sel,
                                               input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y);
    case (sel)
      3'b000:  bit_op = ~x;
      3'b001:  bit_op = x & y;
      3'b010:  bit_op = x | y;
      3'b011:  bit_op = x ^ y;
      3'b100:  bit_op = ~(x & y);
      3'b101:  bit_op = ~(x | y);
      3'b110:  bit_op = ~(x ^ y);
      default: bit_op = x;
    endcase
  endfunction

  // Result with the current beat merged in; used both for the chunk write and
  // to derive zero from the fully assembled value on the last beat.
  always_comb begin
    chunk_res     = bit_op(op_q, a_q[cnt], b_q[cnt]);
    res_next      = res_q;
    res_next[cnt] = chunk_res;
  end

  assign result = res_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      zero      <= 1'b0;
      res_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          res_q[cnt] <= chunk_res;
          if (cnt == LAST) begin
            zero      <= (res_next == '0);
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
module tb_logic_unit_serial;

  logic        clock = 1'b0;
  logic        reset;

  // 32-bit, 8-bit chunk instance
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  // 16-bit single-beat instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero, s_busy;
  logic [2:0]  s_op;
  logic [15:0] s_a, s_b, s_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  logic_unit_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  logic_unit_serial #(.WIDTH(16), .CHUNK(16)) dut_s (
    .clock(clock), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .zero(s_zero), .busy(s_busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Starts at #1 after an edge with the unit idle. Returns result, zero,
  // accept-to-out_valid latency in edges, and busy cycles seen.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output int lat, output int nbusy);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 3'($urandom_range(0, 7));
    lat = 0;
    nbusy = 0;
    while (!out_valid && lat < 20) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
    r = result;
    z = zero;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        z;
  int          lat, nbusy, seen;

  initial begin
    tbl[0]  = '{3'b000, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h5A5A5A5A, 1'b0};
    tbl[1]  = '{3'b001, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h05A005A0, 1'b0};
    tbl[2]  = '{3'b010, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hAFF5AFF5, 1'b0};
    tbl[3]  = '{3'b011, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hAA55AA55, 1'b0};
    tbl[4]  = '{3'b100, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hFA5FFA5F, 1'b0};
    tbl[5]  = '{3'b101, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h500A500A, 1'b0};
    tbl[6]  = '{3'b110, 32'hA5A5A5A5, 32'h0FF00FF0, 32'h55AA55AA, 1'b0};
    tbl[7]  = '{3'b111, 32'hA5A5A5A5, 32'h0FF00FF0, 32'hA5A5A5A5, 1'b0};
    tbl[8]  = '{3'b111, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0};
    tbl[9]  = '{3'b000, 32'h0F0F00FF, 32'h12345678, 32'hF0F0FF00, 1'b0};
    tbl[10] = '{3'b001, 32'hFFFF0000, 32'h00FFFF00, 32'h00FF0000, 1'b0};
    tbl[11] = '{3'b011, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1};
    tbl[12] = '{3'b111, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    step(); step();
    reset = 1'b0;

    check("rst in_ready",  32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy",      32'(busy), 32'd0);
    check("rst result",    result, 32'd0);
    check("rst zero",      32'(zero), 32'd0);

    // Table: op sweep, NOT, AND then XOR back-to-back, pass-through cases
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat, nbusy);
      check($sformatf("vec%0d result", i), r, tbl[i].res);
      check($sformatf("vec%0d zero", i), 32'(z), 32'(tbl[i].z));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d busy cycles", i), 32'(nbusy), 32'd4);
    end

    // zero held after leaving DONE
    check("zero held in idle", 32'(zero), 32'd1);

    // Unwritten chunks keep the previous result while BUSY
    do_op(3'b111, 32'hA5A5A5A5, 32'h0, r, z, lat, nbusy);
    in_valid = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'h0;
    step();
    in_valid = 1'b0;
    step();
    check("partial result", result, 32'hA5A5A500);
    seen = 0;
    while (!out_valid && seen < 20) begin step(); seen++; end
    check("not ffffffff result", result, 32'h00000000);
    check("not ffffffff zero", 32'(zero), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Backpressure with a pending op held on the input
    in_valid = 1'b1; op = 3'b001; a = 32'hFFFF0000; b = 32'h00FFFF00;
    step();
    op = 3'b010; a = 32'h12340000; b = 32'h00005678;
    seen = 0;
    while (!out_valid && seen < 20) begin step(); seen++; end
    check("bp first result", result, 32'h00FF0000);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("bp%0d result", i), result, 32'h00FF0000);
      check($sformatf("bp%0d zero", i), 32'(zero), 32'd0);
      check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("bp pending accepted", 32'(busy), 32'd1);
    seen = 0;
    while (!out_valid && seen < 20) begin step(); seen++; end
    check("bp pending result", result, 32'h12345678);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset on the 2nd BUSY cycle of NOR(0,0)
    in_valid = 1'b1; op = 3'b101; a = 32'h0; b = 32'h0;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst result", result, 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("mid rst no out_valid", 32'(seen), 32'd0);

    // Single-beat configuration
    s_in_valid = 1'b1; s_op = 3'b110; s_a = 16'h1234; s_b = 16'h1234;
    step();
    s_in_valid = 1'b0; s_a = 16'h0; s_b = 16'hFFFF;
    check("sb busy", 32'(s_busy), 32'd1);
    check("sb out_valid early", 32'(s_out_valid), 32'd0);
    step();
    check("sb out_valid", 32'(s_out_valid), 32'd1);
    check("sb result", 32'(s_result), 32'h0000FFFF);
    check("sb zero", 32'(s_zero), 32'd0);
    s_out_ready = 1'b1; step(); s_out_ready = 1'b0;
    check("sb back idle", 32'(s_in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
